// File: rtl/fetch_unit_pkg.sv
// Shared widths and FSM state encoding for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned FETCH_PC_W     = 10;
  localparam int unsigned FETCH_INSTR_W  = 32;
  localparam int unsigned FETCH_FQ_DEPTH = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port and instruction-queue handshake of the fetch unit.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W    = FETCH_PC_W,
  parameter int unsigned INSTR_W = FETCH_INSTR_W
) ();

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    pc_out;
  logic               instr_valid;
  logic               iq_full;

  modport master (
    output imem_addr, instr_out, pc_out, instr_valid,
    input  imem_rdata, iq_full
  );

  modport slave (
    input  imem_addr, instr_out, pc_out, instr_valid,
    output imem_rdata, iq_full
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head reads as zero while empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 42,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  // A write at full is accepted only when a read frees the slot in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with credit-limited requests, redirect flush and halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W     = FETCH_PC_W,
  parameter int unsigned INSTR_W  = FETCH_INSTR_W,
  parameter int unsigned FQ_DEPTH = FETCH_FQ_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  fetch_unit_if.master    bus
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = PC_W + INSTR_W;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            pending_q, pending_d;
  logic            issue_c;

  logic [CW-1:0]   fq_count;
  logic            fq_empty;
  logic            fq_full;
  logic            fq_wr;
  logic            fq_rd;
  logic [EW-1:0]   fq_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= '0;
      req_pc_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      pending_q <= pending_d;
    end
  end

  // Credits count both queued entries and the response still in flight.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    pending_d = 1'b0;
    issue_c   = 1'b0;

    if (state_q == RUN && !redirect &&
        ((SW'(fq_count) + SW'(pending_q)) < SW'(FQ_DEPTH))) begin
      issue_c = 1'b1;
    end

    if (issue_c) begin
      pc_d      = pc_q + PC_W'(1);
      req_pc_d  = pc_q;
      pending_d = 1'b1;
    end

    if (redirect) begin
      state_d = REDIR;
      pc_d    = redirect_pc;
    end else begin
      case (state_q)
        RUN:     if (halt) state_d = HALT;
        REDIR:   state_d = RUN;
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  assign fq_wr = pending_q && !redirect;
  assign fq_rd = bus.instr_valid && !bus.iq_full;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .wr_en   (fq_wr),
    .wr_data ({bus.imem_rdata, req_pc_q}),
    .rd_en   (fq_rd),
    .rd_data (fq_head),
    .count   (fq_count),
    .empty   (fq_empty),
    .full    (fq_full)
  );

  assign pc              = pc_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = !fq_empty && !redirect;
  assign bus.instr_out   = fq_head[EW-1:PC_W];
  assign bus.pc_out      = fq_head[PC_W-1:0];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fq_full && fq_wr && !fq_rd));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency instruction memory model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       redirect;
  logic [9:0] redirect_pc;
  logic       halt;
  logic [9:0] pc;

  int n_chk = 0;
  int n_bad = 0;

  fetch_unit_if #(.PC_W(10), .INSTR_W(32)) bus ();

  fetch_unit #(.PC_W(10), .INSTR_W(32), .FQ_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .pc          (pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [9:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  // Instruction memory: data for the address sampled at an edge appears after that edge.
  always @(posedge clk) bus.imem_rdata <= word_at(bus.imem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next offered instruction, check it, and consume it.
  task automatic deliver(input string tag, input logic [9:0] exp_pc);
    int n = 0;
    while (!bus.instr_valid && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, 64'(bus.instr_valid), 64'd1);
    chk({tag, "_pc"}, 64'(bus.pc_out), 64'(exp_pc));
    chk({tag, "_ins"}, 64'(bus.instr_out), 64'(word_at(exp_pc)));
    step();
  endtask

  task automatic wait_count3();
    int n = 0;
    while (dut.u_fifo.count != 3'd3 && n < 6) begin
      step();
      n++;
    end
    chk("fq_cnt3", 64'(dut.u_fifo.count), 64'd3);
    chk("pend1", 64'(dut.pending_q), 64'd1);
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; bus.iq_full = 1'b0;
    step();
    step();
    chk("rst_vld", 64'(bus.instr_valid), 64'd0);
    chk("rst_ins", 64'(bus.instr_out), 64'd0);
    chk("rst_pco", 64'(bus.pc_out), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);

    // Free run: first instruction two cycles after its request, then one per cycle.
    rst = 1'b0;
    #1;
    chk("c0_addr", 64'(bus.imem_addr), 64'd0);
    step();
    chk("c1_vld", 64'(bus.instr_valid), 64'd0);
    chk("c1_addr", 64'(bus.imem_addr), 64'd1);
    step();
    chk("c2_vld", 64'(bus.instr_valid), 64'd1);
    chk("c2_pc", 64'(bus.pc_out), 64'd0);
    chk("c2_ins", 64'(bus.instr_out), 64'h1000_0000);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("run_vld", 64'(bus.instr_valid), 64'd1);
      chk("run_pc", 64'(bus.pc_out), 64'(i));
      chk("run_ins", 64'(bus.instr_out), 64'(word_at(10'(i))));
    end

    // Back-pressure: queue fills to depth, requests stop, pc freezes.
    bus.iq_full = 1'b1;
    repeat (10) step();
    chk("bp_cnt", 64'(dut.u_fifo.count), 64'd4);
    chk("bp_pc", 64'(pc), 64'd9);
    chk("bp_addr", 64'(bus.imem_addr), 64'd9);
    chk("bp_vld", 64'(bus.instr_valid), 64'd1);
    chk("bp_head", 64'(bus.pc_out), 64'd5);
    bus.iq_full = 1'b0;
    for (int i = 5; i <= 11; i++) deliver("bp_rel", 10'(i));

    // Redirect with three queued entries and one response in flight.
    bus.iq_full = 1'b1;
    wait_count3();
    bus.iq_full = 1'b0;
    redirect = 1'b1; redirect_pc = 10'h200;
    #1;
    chk("rd_vld0", 64'(bus.instr_valid), 64'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("rd_vld1", 64'(bus.instr_valid), 64'd0);
    chk("rd_cnt", 64'(dut.u_fifo.count), 64'd0);
    chk("rd_st", 64'(dut.state_q), 64'(REDIR));
    chk("rd_pc", 64'(pc), 64'h200);
    deliver("rd_a", 10'h200);
    deliver("rd_b", 10'h201);

    // Address wrap at the top of the fetch space.
    redirect = 1'b1; redirect_pc = 10'h3FE;
    step();
    redirect = 1'b0;
    deliver("wr_a", 10'h3FE);
    deliver("wr_b", 10'h3FF);
    deliver("wr_c", 10'h000);
    deliver("wr_d", 10'h001);

    // Halt: the in-flight request completes, then fetch stops until redirect.
    redirect = 1'b1; redirect_pc = 10'd5;
    step();
    redirect = 1'b0;
    step();
    chk("h_pc5", 64'(pc), 64'd5);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("h_st", 64'(dut.state_q), 64'(HALT));
    deliver("h_last", 10'd5);
    repeat (3) step();
    chk("h_vld", 64'(bus.instr_valid), 64'd0);
    chk("h_pcfz", 64'(pc), 64'd6);
    chk("h_st2", 64'(dut.state_q), 64'(HALT));
    chk("h_cnt", 64'(dut.u_fifo.count), 64'd0);
    redirect = 1'b1; redirect_pc = 10'h10;
    step();
    redirect = 1'b0;
    deliver("h_res_a", 10'h10);
    deliver("h_res_b", 10'h11);
    halt = 1'b1; redirect = 1'b1; redirect_pc = 10'h40;
    step();
    halt = 1'b0; redirect = 1'b0;
    chk("hr_st", 64'(dut.state_q), 64'(REDIR));
    deliver("hr_a", 10'h40);
    deliver("hr_b", 10'h41);
    chk("hr_run", 64'(dut.state_q), 64'(RUN));

    // Reset with credits exhausted and a response in flight.
    bus.iq_full = 1'b1;
    wait_count3();
    rst = 1'b1;
    step();
    chk("mr_vld", 64'(bus.instr_valid), 64'd0);
    chk("mr_ins", 64'(bus.instr_out), 64'd0);
    chk("mr_pco", 64'(bus.pc_out), 64'd0);
    chk("mr_addr", 64'(bus.imem_addr), 64'd0);
    chk("mr_pc", 64'(pc), 64'd0);
    chk("mr_cnt", 64'(dut.u_fifo.count), 64'd0);
    rst = 1'b0; bus.iq_full = 1'b0;
    deliver("mr_a", 10'd0);
    deliver("mr_b", 10'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
